// File: rtl/note_rom_arbiter.sv
// note_rom_arbiter: round-robin sharing of one synchronous note-table ROM
// among NUM_CH pitch lookup channels. Accepts one lookup per clock; each
// result returns to the issuing channel two cycles after its ack, with the
// channel tag following the ROM's one-cycle read latency.
module note_rom_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH*ADDR_W-1:0] i_addr,
    output logic [NUM_CH-1:0]        o_ack,
    output logic [NUM_CH-1:0]        o_valid,
    output logic [DATA_W-1:0]        o_data,
    output logic [ADDR_W-1:0]        o_rom_addr,
    input  logic [DATA_W-1:0]        i_rom_data,
    output logic                     o_busy
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] ptr;
    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_next;
    int               cand;

    // Tag of the lookup whose ROM address was just registered (stage 1)
    // and of the lookup whose ROM data is being read out (stage 2).
    logic             s1_vld;
    logic [PTR_W-1:0] s1_tag;
    logic             s2_vld;
    logic [PTR_W-1:0] s2_tag;

    // Round-robin search starting at ptr, wrapping past NUM_CH-1 to 0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!gnt_found && i_req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(cand);
            end
        end
    end

    // Pointer moves to the channel after the one just granted.
    always_comb begin
        if (int'(gnt_idx) == NUM_CH - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + PTR_W'(1);
        end
    end

    // Grant stage: register ROM address, ack pulse and stage-1 tag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr        <= '0;
            o_rom_addr <= '0;
            o_ack      <= '0;
            s1_vld     <= 1'b0;
            s1_tag     <= '0;
        end else if (gnt_found) begin
            ptr        <= ptr_next;
            o_rom_addr <= i_addr[gnt_idx*ADDR_W +: ADDR_W];
            o_ack      <= ONE_HOT0 << gnt_idx;
            s1_vld     <= 1'b1;
            s1_tag     <= gnt_idx;
        end else begin
            o_ack      <= '0;
            s1_vld     <= 1'b0;
        end
    end

    // Stage-2 tag tracks the ROM registering its output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld <= 1'b0;
            s2_tag <= '0;
        end else begin
            s2_vld <= s1_vld;
            s2_tag <= s1_tag;
        end
    end

    // Output stage: capture ROM data with the matching one-hot valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= '0;
            o_data  <= '0;
        end else if (s2_vld) begin
            o_valid <= ONE_HOT0 << s2_tag;
            o_data  <= i_rom_data;
        end else begin
            o_valid <= '0;
        end
    end

    assign o_busy = s1_vld | s2_vld;

endmodule

// File: tb/tb_note_rom_arbiter.sv
// Self-checking bench for note_rom_arbiter: directed scenarios followed by
// randomized requesters, all compared every cycle against a grant-history
// model (ack at the grant cycle, valid two cycles later, busy in between).
module tb_note_rom_arbiter;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int MAXC   = 8192;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n;
    logic [NUM_CH-1:0]        i_req;
    logic [NUM_CH*ADDR_W-1:0] i_addr;
    logic [NUM_CH-1:0]        o_ack;
    logic [NUM_CH-1:0]        o_valid;
    logic [DATA_W-1:0]        o_data;
    logic [ADDR_W-1:0]        o_rom_addr;
    logic [DATA_W-1:0]        i_rom_data;
    logic                     o_busy;

    note_rom_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .o_ack      (o_ack),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural note-table ROM with one-cycle read latency.
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge i_clk) i_rom_data <= mem[o_rom_addr];

    int checks   = 0;
    int failures = 0;

    // Model: grant history indexed by cycle number.
    int                gch   [0:MAXC];
    logic [ADDR_W-1:0] gaddr [0:MAXC];
    int                cyc;
    int                ptr;
    logic [ADDR_W-1:0] m_rom_addr;

    logic [NUM_CH-1:0] hold;
    int                ack_log[$];
    int                ack1_seen;
    int                val1_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit found;
        int ch;
        cyc++;
        gch[cyc] = -1;
        found = 0;
        if (!i_rst_n) begin
            ptr        = 0;
            m_rom_addr = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch = (ptr + i) % NUM_CH;
                if (!found && i_req[ch]) begin
                    found      = 1;
                    gch[cyc]   = ch;
                    gaddr[cyc] = i_addr[ch*ADDR_W +: ADDR_W];
                    m_rom_addr = gaddr[cyc];
                    ptr        = (ch + 1) % NUM_CH;
                end
            end
        end
    endtask

    task automatic model_reset();
        ptr         = 0;
        m_rom_addr  = '0;
        gch[cyc]    = -1;
        gch[cyc-1]  = -1;
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] eack;
        logic [NUM_CH-1:0] eval;
        eack = '0;
        eval = '0;
        if (gch[cyc] >= 0)   eack[gch[cyc]] = 1'b1;
        if (gch[cyc-2] >= 0) eval[gch[cyc-2]] = 1'b1;
        check("ack", 32'(o_ack), 32'(eack));
        check("valid", 32'(o_valid), 32'(eval));
        check("busy", 32'(o_busy), 32'(gch[cyc] >= 0 || gch[cyc-1] >= 0));
        check("rom_addr", 32'(o_rom_addr), 32'(m_rom_addr));
        if (gch[cyc-2] >= 0) check("data", 32'(o_data), 32'(mem[gaddr[cyc-2]]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(o_ack), 32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_rom_addr"}, 32'(o_rom_addr), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    // One clock: model advances, DUT clocks, outputs checked at negedge,
    // then requesters drop i_req on their ack unless holding.
    task automatic step();
        model_edge();
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs();
        for (int k = 0; k < NUM_CH; k++) begin
            if (o_ack[k]) begin
                ack_log.push_back(k);
                if (!hold[k]) i_req[k] = 1'b0;
            end
        end
        if (o_ack[1])   ack1_seen++;
        if (o_valid[1]) val1_seen++;
    endtask

    task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
        i_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic async_reset();
        i_rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
        mem[5] = 16'h1234;
        for (int i = 0; i <= MAXC; i++) begin
            gch[i]   = -1;
            gaddr[i] = '0;
        end
        cyc        = 2;
        ptr        = 0;
        m_rom_addr = '0;
        hold       = '0;
        ack1_seen  = 0;
        val1_seen  = 0;
        i_rst_n    = 1'b0;
        i_req      = '0;
        i_addr     = '0;

        // Reset state
        @(negedge i_clk);
        check_all_zero("rst");
        step();
        step();
        i_rst_n = 1'b1;

        // Single request, ROM[5] = 1234
        set_addr(0, 8'h05);
        i_req = 4'b0001;
        step();
        check("t1_ack", 32'(o_ack), 32'h1);
        check("t1_rom_addr", 32'(o_rom_addr), 32'h05);
        check("t1_busy_a", 32'(o_busy), 32'h1);
        step();
        check("t1_busy_b", 32'(o_busy), 32'h1);
        step();
        check("t1_valid", 32'(o_valid), 32'h1);
        check("t1_data", 32'(o_data), 32'h1234);
        check("t1_busy_c", 32'(o_busy), 32'h0);
        step();

        // All four together, fresh pointer
        async_reset();
        step();
        i_rst_n = 1'b1;
        for (int k = 0; k < NUM_CH; k++) set_addr(k, ADDR_W'(k + 1));
        i_req = 4'b1111;
        ack_log.delete();
        for (int i = 0; i < 7; i++) step();
        check("t2_count", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t2_order", 32'((i < ack_log.size()) ? ack_log[i] : -1), 32'(i));

        // Fairness: 0 and 2 hold request continuously
        hold  = 4'b0101;
        i_req = 4'b0101;
        ack_log.delete();
        for (int i = 0; i < 8; i++) step();
        hold  = '0;
        i_req = '0;
        check("t3_count", 32'(ack_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check("t3_alt", 32'((i < ack_log.size()) ? ack_log[i] : -1), 32'((i % 2) * 2));
        for (int i = 0; i < 3; i++) step();

        // Wrap-around: pointer now 3; channels 1 and 3 together
        ack_log.delete();
        i_req = 4'b1010;
        for (int i = 0; i < 3; i++) step();
        i_req = 4'b1111;
        for (int i = 0; i < 6; i++) step();
        check("t4_count", 32'(ack_log.size()), 32'd6);
        check("t4_first", 32'((ack_log.size() > 0) ? ack_log[0] : -1), 32'd3);
        check("t4_second", 32'((ack_log.size() > 1) ? ack_log[1] : -1), 32'd1);
        check("t4_ptr", 32'((ack_log.size() > 2) ? ack_log[2] : -1), 32'd2);

        // Reset in the cycle after an ack
        set_addr(2, 8'h33);
        i_req = 4'b0100;
        step();
        async_reset();
        i_req = 4'b1111;
        step();
        step();
        i_rst_n = 1'b1;
        ack_log.delete();
        for (int i = 0; i < 7; i++) step();
        check("t5_first", 32'((ack_log.size() > 0) ? ack_log[0] : -1), 32'd0);

        // Withdrawn request on channel 1
        ack1_seen = 0;
        val1_seen = 0;
        i_req = 4'b0011;
        step();
        i_req[1] = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_ack1", 32'(ack1_seen), 32'd0);
        check("t6_val1", 32'(val1_seen), 32'd0);

        // Randomized requesters with occasional withdrawal and one reset
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!i_req[k]) begin
                    if ($urandom_range(2, 0) == 0) begin
                        set_addr(k, ADDR_W'($urandom));
                        i_req[k] = 1'b1;
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    i_req[k] = 1'b0;
                end
            end
            if (n == 200) begin
                async_reset();
                step();
                i_rst_n = 1'b1;
            end
            step();
        end
        i_req = '0;
        for (int i = 0; i < 4; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
